// File: rtl/riscv_pkg.sv
// riscv_pkg - shared types and helpers for the data-memory store buffer.
//   ACC_BYTE/ACC_HALF/ACC_WORD : one-hot access size encodings (access_size_i)
//   sb_entry_t                 : one buffered store {word_adr, data, be}
//   sb_lane_t                  : lane-aligned store data plus byte enables
//   store_lanes()              : replicates store data across lanes and
//                                builds the byte enables from size/offset
package riscv_pkg;

  localparam logic [2:0] ACC_BYTE = 3'b001;
  localparam logic [2:0] ACC_HALF = 3'b010;
  localparam logic [2:0] ACC_WORD = 3'b100;

  typedef struct packed {
    logic [29:0] word_adr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } sb_lane_t;

  // Replicating the data into every lane lets the enables alone pick the
  // target bytes, so no data shifter is needed.
  function automatic sb_lane_t store_lanes(input logic [2:0]  size,
                                           input logic [1:0]  ofs,
                                           input logic [31:0] sd);
    sb_lane_t r;
    case (size)
      ACC_BYTE: begin
        r.be   = 4'b0001 << ofs;
        r.data = {4{sd[7:0]}};
      end
      ACC_HALF: begin
        r.be   = 4'b0011 << ofs;
        r.data = {2{sd[15:0]}};
      end
      ACC_WORD: begin
        r.be   = 4'b1111;
        r.data = sd;
      end
      default: begin
        r.be   = 4'b0000;
        r.data = sd;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// sb_fwd_merge - load forwarding from the store buffer.
//   entries_i  : store buffer entry array
//   head_i     : index of the oldest entry
//   count_i    : number of valid entries (valid entries are head..head+count-1)
//   word_adr_i : word address of the load
//   mem_data_i : backing memory read data
//   data_o     : per-byte-lane merge, youngest matching entry wins, else memory
module sb_fwd_merge
  import riscv_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int PTR_W = $clog2(SB_DEPTH)
) (
  input  sb_entry_t [SB_DEPTH-1:0] entries_i,
  input  logic [PTR_W-1:0]         head_i,
  input  logic [PTR_W:0]           count_i,
  input  logic [29:0]              word_adr_i,
  input  logic [31:0]              mem_data_i,
  output logic [31:0]              data_o
);

  sb_entry_t  e_s;
  logic       hit_s;
  logic [7:0] byte_s;

  // Walk oldest to youngest so a later hit overrides an earlier one.
  always_comb begin
    data_o = mem_data_i;
    e_s    = '0;
    hit_s  = 1'b0;
    byte_s = 8'h00;
    for (int l = 0; l < 4; l++) begin
      byte_s = mem_data_i[8*l +: 8];
      for (int k = 0; k < SB_DEPTH; k++) begin
        e_s    = entries_i[head_i + PTR_W'(k)];
        hit_s  = ((PTR_W+1)'(k) < count_i) && (e_s.word_adr == word_adr_i) && e_s.be[l];
        byte_s = hit_s ? e_s.data[8*l +: 8] : byte_s;
      end
      data_o[8*l +: 8] = byte_s;
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer - data-memory responder with an in-order store buffer.
//   clk, reset_n (async, active-low)
//   adr_v_i/adr_i/is_store_i/store_data_i/access_size_i : core request
//   load_data_o : aligned load word, same cycle, with store forwarding
//   stall_o     : store refused this cycle (buffer full)
//   sb_empty_o  : no pending stores
//   mem_rd_adr_o/mem_rd_data_i : backing memory async read port
//   mem_wr_req_o/adr/data/be, mem_wr_gnt_i : backing memory write port
// Optional build macro SB_COALESCE_EN: merge a store into the youngest entry
// when it hits the same word and that entry is not the one being drained.
module dmem_store_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            stall_o,
  output logic            sb_empty_o,
  output logic [XLEN-1:0] mem_rd_adr_o,
  input  logic [XLEN-1:0] mem_rd_data_i,
  output logic            mem_wr_req_o,
  output logic [XLEN-1:0] mem_wr_adr_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic [3:0]      mem_wr_be_o,
  input  logic            mem_wr_gnt_i
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(SB_DEPTH);

  sb_entry_t [SB_DEPTH-1:0] entries_q;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty_s, full_s, store_req_s, push_s, pop_s, merge_s;
  sb_lane_t         lane_s;
  sb_entry_t        head_e_s;

`ifdef SB_COALESCE_EN
  logic [PTR_W-1:0] youngest_s;
  sb_entry_t        young_e_s, merged_s;

  // Merge candidate: youngest entry, never the head while it is being offered.
  always_comb begin
    youngest_s = tail_q - {{(PTR_W-1){1'b0}}, 1'b1};
    young_e_s  = entries_q[youngest_s];
    merge_s    = store_req_s && (count_q > (PTR_W+1)'(1)) &&
                 (young_e_s.word_adr == adr_i[31:2]);
    merged_s   = young_e_s;
    merged_s.be = young_e_s.be | lane_s.be;
    for (int l = 0; l < 4; l++) begin
      merged_s.data[8*l +: 8] = lane_s.be[l] ? lane_s.data[8*l +: 8]
                                             : young_e_s.data[8*l +: 8];
    end
  end
`else
  assign merge_s = 1'b0;
`endif

  // Request decode, occupancy and pointer next-state.
  always_comb begin
    lane_s      = store_lanes(access_size_i, adr_i[1:0], store_data_i);
    empty_s     = (count_q == {(PTR_W+1){1'b0}});
    full_s      = (count_q == FULL_CNT);
    store_req_s = adr_v_i & is_store_i;
    push_s      = store_req_s & ~full_s & ~merge_s;
    pop_s       = ~empty_s & mem_wr_gnt_i;
    stall_o     = store_req_s & full_s & ~merge_s;
    head_d      = pop_s  ? head_q + {{(PTR_W-1){1'b0}}, 1'b1} : head_q;
    tail_d      = push_s ? tail_q + {{(PTR_W-1){1'b0}}, 1'b1} : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Write port presents the head entry; zeroed while empty.
  always_comb begin
    head_e_s      = entries_q[head_q];
    mem_wr_req_o  = ~empty_s;
    mem_wr_adr_o  = empty_s ? '0 : {head_e_s.word_adr, 2'b00};
    mem_wr_data_o = empty_s ? '0 : head_e_s.data;
    mem_wr_be_o   = empty_s ? 4'b0000 : head_e_s.be;
    sb_empty_o    = empty_s;
    mem_rd_adr_o  = {adr_i[XLEN-1:2], 2'b00};
  end

  // Buffer state; reset discards every pending store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_s) begin
        entries_q[tail_q] <= '{word_adr: adr_i[31:2], data: lane_s.data, be: lane_s.be};
      end
`ifdef SB_COALESCE_EN
      if (merge_s) begin
        entries_q[youngest_s] <= merged_s;
      end
`endif
    end
  end

  sb_fwd_merge #(.SB_DEPTH(SB_DEPTH)) u_fwd (
    .entries_i  (entries_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .word_adr_i (adr_i[31:2]),
    .mem_data_i (mem_rd_data_i),
    .data_o     (load_data_o)
  );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer - directed vector bench for dmem_store_buffer
// (SB_DEPTH = 4). Expected write-port contents follow the macro
// SB_COALESCE_EN in the same way as the design.
module tb_dmem_store_buffer;

  localparam logic [2:0] B = 3'b001;
  localparam logic [2:0] H = 3'b010;
  localparam logic [2:0] W = 3'b100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adr_v_i, is_store_i, mem_wr_gnt_i;
  logic [31:0] adr_i, store_data_i, mem_rd_data_i;
  logic [2:0]  access_size_i;
  logic [31:0] load_data_o, mem_rd_adr_o, mem_wr_adr_o, mem_wr_data_o;
  logic        stall_o, sb_empty_o, mem_wr_req_o;
  logic [3:0]  mem_wr_be_o;

  dmem_store_buffer #(.XLEN(32), .SB_DEPTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adr_v_i       (adr_v_i),
    .adr_i         (adr_i),
    .is_store_i    (is_store_i),
    .store_data_i  (store_data_i),
    .access_size_i (access_size_i),
    .load_data_o   (load_data_o),
    .stall_o       (stall_o),
    .sb_empty_o    (sb_empty_o),
    .mem_rd_adr_o  (mem_rd_adr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .mem_wr_req_o  (mem_wr_req_o),
    .mem_wr_adr_o  (mem_wr_adr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_wr_be_o   (mem_wr_be_o),
    .mem_wr_gnt_i  (mem_wr_gnt_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] adr;
    logic        st;
    logic [31:0] sd;
    logic [2:0]  sz;
    logic [31:0] rd;
    logic        gnt;
    logic        chk_ld;
    logic [31:0] ld;
    logic        stall;
    logic [31:0] wadr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur   = -1;

  // A zero expected byte enable means the buffer is expected to be empty.
  task automatic add(input logic v, input logic [31:0] adr, input logic st,
                     input logic [31:0] sd, input logic [2:0] sz,
                     input logic [31:0] rd, input logic gnt, input logic chk,
                     input logic [31:0] ld, input logic stall,
                     input logic [31:0] wadr, input logic [31:0] wdata,
                     input logic [3:0] be);
    vec_t t;
    t = '{v, adr, st, sd, sz, rd, gnt, chk, ld, stall, wadr, wdata, be};
    vq.push_back(t);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %h, expected %h", nm, cur, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] adr, input logic st,
                       input logic [31:0] sd, input logic [2:0] sz,
                       input logic [31:0] rd, input logic gnt);
    adr_v_i = v; adr_i = adr; is_store_i = st; store_data_i = sd;
    access_size_i = sz; mem_rd_data_i = rd; mem_wr_gnt_i = gnt;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b0);

    // basic store / forward / drain
    add(1'b1, 32'h100, 1'b0, 32'h0, W, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 4'h0);
    add(1'b1, 32'h100, 1'b1, 32'h11223344, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    add(1'b1, 32'h100, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h11223344, 1'b0, 32'h100, 32'h11223344, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h100, 32'h11223344, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    // byte + half merge on load, granted head still forwards
    add(1'b1, 32'h102, 1'b1, 32'hAB, B, 32'h55555555, 1'b0, 1'b1, 32'h55555555, 1'b0, 32'h0, 32'h0, 4'h0);
    add(1'b1, 32'h100, 1'b1, 32'hCDEF, H, 32'h55555555, 1'b0, 1'b1, 32'h55AB5555, 1'b0, 32'h100, 32'hABABABAB, 4'h4);
    add(1'b1, 32'h100, 1'b0, 32'h0, W, 32'h55555555, 1'b0, 1'b1, 32'h55ABCDEF, 1'b0, 32'h100, 32'hABABABAB, 4'h4);
    add(1'b1, 32'h104, 1'b0, 32'h0, W, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h100, 32'hABABABAB, 4'h4);
    add(1'b1, 32'h100, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h00ABCDEF, 1'b0, 32'h100, 32'hABABABAB, 4'h4);
    add(1'b1, 32'h100, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0000CDEF, 1'b0, 32'h100, 32'hCDEFCDEF, 4'h3);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    // fill to full, stall, stall persists across the popping cycle
    for (int i = 0; i < 4; i++) begin
      add(1'b1, 32'h300 + 32'(4*i), 1'b1, 32'(i+1), W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0,
          (i == 0) ? 32'h0 : 32'h300, (i == 0) ? 32'h0 : 32'h1, (i == 0) ? 4'h0 : 4'hF);
    end
    add(1'b1, 32'h310, 1'b1, 32'h55, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h300, 32'h1, 4'hF);
    add(1'b1, 32'h310, 1'b1, 32'h55, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h300, 32'h1, 4'hF);
    add(1'b1, 32'h310, 1'b1, 32'h55, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h304, 32'h2, 4'hF);
    add(1'b1, 32'h310, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h55, 1'b0, 32'h304, 32'h2, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h304, 32'h2, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h308, 32'h3, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h30C, 32'h4, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h310, 32'h55, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    // streaming with gnt held high; gnt while empty is ignored
    add(1'b1, 32'h400, 1'b1, 32'hA0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    add(1'b1, 32'h404, 1'b1, 32'hA1, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h400, 32'hA0, 4'hF);
    add(1'b1, 32'h408, 1'b1, 32'hA2, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h404, 32'hA1, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h408, 32'hA2, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    // same-word byte stores behind a non-head entry
    add(1'b1, 32'h500, 1'b1, 32'h99, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    add(1'b1, 32'h200, 1'b1, 32'h01, B, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h500, 32'h99, 4'hF);
    add(1'b1, 32'h201, 1'b1, 32'h02, B, 32'h0, 1'b0, 1'b1, 32'h00000001, 1'b0, 32'h500, 32'h99, 4'hF);
    add(1'b1, 32'h200, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h00000201, 1'b0, 32'h500, 32'h99, 4'hF);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h500, 32'h99, 4'hF);
`ifdef SB_COALESCE_EN
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h200, 32'h01010201, 4'h3);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
`else
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h200, 32'h01010101, 4'h1);
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h200, 32'h02020202, 4'h2);
`endif
    add(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);

    // reset state, checked while reset is held
    repeat (2) @(negedge clk);
    #1;
    check("rst_empty", 32'(sb_empty_o), 32'h1);
    check("rst_req", 32'(mem_wr_req_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    n_vec++;
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      cur = i;
      drive(vq[i].v, vq[i].adr, vq[i].st, vq[i].sd, vq[i].sz, vq[i].rd, vq[i].gnt);
      #1;
      if (vq[i].chk_ld) check("load_data", load_data_o, vq[i].ld);
      check("rd_adr", mem_rd_adr_o, {vq[i].adr[31:2], 2'b00});
      check("stall", 32'(stall_o), 32'(vq[i].stall));
      check("wr_req", 32'(mem_wr_req_o), 32'(vq[i].be != 4'h0));
      check("empty", 32'(sb_empty_o), 32'(vq[i].be == 4'h0));
      check("wr_adr", mem_wr_adr_o, vq[i].wadr);
      check("wr_data", mem_wr_data_o, vq[i].wdata);
      check("wr_be", 32'(mem_wr_be_o), 32'(vq[i].be));
      n_vec++;
    end

    // reset mid-operation: pending stores discarded, req drops at once
    cur = 1000;
    @(negedge clk);
    drive(1'b1, 32'h700, 1'b1, 32'h77, W, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h704, 1'b1, 32'h78, W, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, W, 32'h0, 1'b0);
    #1;
    check("pre_rst_req", 32'(mem_wr_req_o), 32'h1);
    n_vec++;
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(mem_wr_req_o), 32'h0);
    check("rst_empty", 32'(sb_empty_o), 32'h1);
    check("rst_wr_adr", mem_wr_adr_o, 32'h0);
    n_vec++;
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h700, 1'b0, 32'h0, W, 32'h12121212, 1'b0);
    #1;
    check("post_rst_load", load_data_o, 32'h12121212);
    check("post_rst_empty", 32'(sb_empty_o), 32'h1);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
